surf_wb_fanout: RTL and testbench
=================================

SURF_WB_FANOUT -- requirements
Module: surf_wb_fanout

Interface
REQ-001 SHALL have parameter NPORTS, default 8: number of indexed downstream Wishbone ports, 1..16.
REQ-002 SHALL have parameter SUB_ADR_BITS, default 6: per-port address width.
REQ-003 SHALL have parameter ADR_WIDTH, default 12: upstream address width, at least SUB_ADR_BITS+IDX+1, where IDX=max(1,clog2(NPORTS)).
REQ-004 SHALL have parameter HI_PORT_EN, default 1: when set, the upper half of the address space routes to a dedicated high port.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum downstream wait before an error response, 1..65535.
REQ-006 SHALL have port wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  upstream classic Wishbone controls.
REQ-009 SHALL have ports wb_adr_i  in  ADR_WIDTH; wb_dat_i  in  32; wb_sel_i  in  4  upstream address, write data, byte selects.
REQ-010 SHALL have ports wb_ack_o, wb_err_o, wb_rty_o  out  1 each, and wb_dat_o  out  32  upstream response.
REQ-011 SHALL have ports m_cyc_o, m_stb_o  out  NPORTS  per-port strobes; m_we_o  out  1; m_adr_o  out  SUB_ADR_BITS; m_dat_o  out  32; m_sel_o  out  4  (shared).
REQ-012 SHALL have ports m_ack_i, m_err_i  in  NPORTS; m_dat_i  in  32*NPORTS  (port p at bits [32p +: 32]).
REQ-013 SHALL have ports h_cyc_o, h_stb_o, h_we_o  out  1; h_adr_o  out  ADR_WIDTH-1; h_dat_o  out  32; h_sel_o  out  4; h_ack_i, h_err_i  in  1; h_dat_i  in  32  (high port).
REQ-014 SHALL have ports clear_stats_i  in  1; timeout_count_o  out  16; last_timeout_port_o  out  5  (16 = high port).

Function
REQ-015 SHALL implement state machine IDLE, ACCESS, RESP.
REQ-016 IDLE: on wb_cyc_i&&wb_stb_i SHALL register address/data/sel/we and decoded target, then enter ACCESS next cycle.
REQ-017 Decode: HI_PORT_EN=1 and wb_adr_i[ADR_WIDTH-1]=1 SHALL select the high port; otherwise index = wb_adr_i[SUB_ADR_BITS +: IDX].
REQ-018 An index >= NPORTS SHALL skip ACCESS, go straight to RESP with error; no downstream strobe asserted.
REQ-019 In ACCESS, cyc/stb SHALL be asserted only to the selected port, registered, zero-glitch; all other ports' cyc/stb low.
REQ-020 Downstream shared outputs SHALL hold the registered request values for the whole ACCESS.
REQ-021 ACCESS SHALL exit on the selected port's ack or err; ack and err together SHALL be treated as err.
REQ-022 ACCESS SHALL count waits from 0; on reaching TIMEOUT_CYCLES without response SHALL drop stb and enter RESP with error.
REQ-023 RESP SHALL last exactly one cycle, asserting wb_ack_o (ok) or wb_err_o (error/timeout), never both, then return to IDLE.
REQ-024 wb_dat_o SHALL hold the captured read data in RESP; it SHALL be 32'hDEADBEEF on error/timeout.
REQ-025 Latency: request sampled at edge N, downstream stb at N+1; slave ack sampled at edge K gives wb_ack_o high K+1; minimum N+2.
REQ-026 Upstream wb_cyc_i low during ACCESS SHALL abort: downstream cyc/stb drop next edge, return to IDLE, no response.
REQ-027 wb_rty_o SHALL be constant 0.
REQ-028 Each timeout SHALL increment timeout_count_o, saturating at 16'hFFFF, and load last_timeout_port_o.
REQ-029 clear_stats_i SHALL zero both; if it coincides with a timeout, the clear SHALL win.

Reset
REQ-030 wb_rst_n_i low SHALL force IDLE, clear all strobes/acks/errs, wb_dat_o=0, stats=0, wait counter=0.
REQ-031 Reset mid-ACCESS SHALL drop downstream cyc/stb immediately (asynchronously), with no upstream response after release.

Verification
REQ-032 Read port 3 (adr 12'h0C4), slave acks 2 cycles after stb with 32'h12345678 -> m_adr_o=6'h04, one-cycle wb_ack_o, wb_dat_o=32'h12345678.
REQ-033 Write to 12'h800, HI_PORT_EN=1 -> h_stb_o only, h_adr_o=11'h000, wb_ack_o once.
REQ-034 NPORTS=6, access adr index 7 -> no strobe, wb_err_o one cycle, dat 32'hDEADBEEF.
REQ-035 Port 1 silent, TIMEOUT_CYCLES=4 -> wb_err_o after timeout, timeout_count_o=1, last_timeout_port_o=1.
REQ-036 wb_cyc_i dropped mid-ACCESS, then wb_rst_n_i pulsed during a new ACCESS -> strobes low, no ack/err, FSM in IDLE.

Source files
------------

// File: rtl/surf_wb_fanout.sv
// Classic Wishbone 1-to-N fanout with an optional high-half port, a per-access wait timeout,
// and timeout statistics. Every request and response is registered; one transaction at a time.
module surf_wb_fanout #(
  parameter int unsigned NPORTS         = 8,
  parameter int unsigned SUB_ADR_BITS   = 6,
  parameter int unsigned ADR_WIDTH      = 12,
  parameter bit          HI_PORT_EN     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [ADR_WIDTH-1:0]      wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  input  logic [3:0]                wb_sel_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic [31:0]               wb_dat_o,
  output logic [NPORTS-1:0]         m_cyc_o,
  output logic [NPORTS-1:0]         m_stb_o,
  output logic                      m_we_o,
  output logic [SUB_ADR_BITS-1:0]   m_adr_o,
  output logic [31:0]               m_dat_o,
  output logic [3:0]                m_sel_o,
  input  logic [NPORTS-1:0]         m_ack_i,
  input  logic [NPORTS-1:0]         m_err_i,
  input  logic [32*NPORTS-1:0]      m_dat_i,
  output logic                      h_cyc_o,
  output logic                      h_stb_o,
  output logic                      h_we_o,
  output logic [ADR_WIDTH-2:0]      h_adr_o,
  output logic [31:0]               h_dat_o,
  output logic [3:0]                h_sel_o,
  input  logic                      h_ack_i,
  input  logic                      h_err_i,
  input  logic [31:0]               h_dat_i,
  input  logic                      clear_stats_i,
  output logic [15:0]               timeout_count_o,
  output logic [4:0]                last_timeout_port_o
);

  localparam int unsigned IDX   = (NPORTS > 2) ? $clog2(NPORTS) : 1;
  localparam int unsigned WAITW = 16;
  localparam logic [31:0] ERR_DATA   = 32'hDEADBEEF;
  localparam logic [4:0]  HI_PORT_ID = 5'd16;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                 state_q, state_d;
  logic [ADR_WIDTH-2:0]   adr_q, adr_d;
  logic [31:0]            wdat_q, wdat_d;
  logic [3:0]             sel_q, sel_d;
  logic                   we_q, we_d;
  logic                   hi_q, hi_d;
  logic [IDX-1:0]         idx_q, idx_d;
  logic [NPORTS-1:0]      m_req_q, m_req_d;
  logic                   h_req_q, h_req_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [31:0]            rdat_q, rdat_d;
  logic [WAITW-1:0]       wait_q, wait_d;
  logic [15:0]            tcnt_q, tcnt_d;
  logic [4:0]             tport_q, tport_d;

  logic                   req_hi, req_bad, timeout_hit;
  logic [IDX-1:0]         req_idx;
  logic [NPORTS-1:0]      req_onehot;
  logic                   rsp_ack, rsp_err;
  logic [31:0]            rsp_dat;

  // Target decode of the incoming upstream address
  always_comb begin
    req_hi  = HI_PORT_EN && wb_adr_i[ADR_WIDTH-1];
    req_idx = wb_adr_i[SUB_ADR_BITS +: IDX];
    req_bad = !req_hi && (32'(req_idx) >= NPORTS);
    req_onehot = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      req_onehot[p] = !req_hi && (req_idx == IDX'(p));
    end
  end

  // Response mux from the currently selected downstream port
  always_comb begin
    rsp_ack = h_ack_i;
    rsp_err = h_err_i;
    rsp_dat = h_dat_i;
    if (!hi_q) begin
      rsp_ack = 1'b0;
      rsp_err = 1'b0;
      rsp_dat = '0;
      for (int p = 0; p < int'(NPORTS); p++) begin
        if (idx_q == IDX'(p)) begin
          rsp_ack = m_ack_i[p];
          rsp_err = m_err_i[p];
          rsp_dat = m_dat_i[32*p +: 32];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    hi_d        = hi_q;
    idx_d       = idx_q;
    m_req_d     = m_req_q;
    h_req_d     = h_req_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdat_d      = rdat_q;
    wait_d      = wait_q;
    tcnt_d      = tcnt_q;
    tport_d     = tport_q;
    timeout_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d  = wb_adr_i[ADR_WIDTH-2:0];
          wdat_d = wb_dat_i;
          sel_d  = wb_sel_i;
          we_d   = wb_we_i;
          hi_d   = req_hi;
          idx_d  = req_idx;
          wait_d = '0;
          if (req_bad) begin
            err_d   = 1'b1;
            rdat_d  = ERR_DATA;
            state_d = RESP;
          end else begin
            m_req_d = req_onehot;
            h_req_d = req_hi;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Upstream abort beats any same-cycle downstream response
        if (!wb_cyc_i) begin
          m_req_d = '0;
          h_req_d = 1'b0;
          state_d = IDLE;
        end else if (rsp_err) begin
          m_req_d = '0;
          h_req_d = 1'b0;
          err_d   = 1'b1;
          rdat_d  = ERR_DATA;
          state_d = RESP;
        end else if (rsp_ack) begin
          m_req_d = '0;
          h_req_d = 1'b0;
          ack_d   = 1'b1;
          rdat_d  = rsp_dat;
          state_d = RESP;
        end else if (wait_q == WAITW'(TIMEOUT_CYCLES - 1)) begin
          m_req_d     = '0;
          h_req_d     = 1'b0;
          err_d       = 1'b1;
          rdat_d      = ERR_DATA;
          timeout_hit = 1'b1;
          state_d     = RESP;
        end else begin
          wait_d = wait_q + WAITW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        m_req_d = '0;
        h_req_d = 1'b0;
      end
    endcase

    if (clear_stats_i) begin
      tcnt_d  = '0;
      tport_d = '0;
    end else if (timeout_hit) begin
      if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
      tport_d = hi_q ? HI_PORT_ID : 5'(idx_q);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      hi_q    <= 1'b0;
      idx_q   <= '0;
      m_req_q <= '0;
      h_req_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      wait_q  <= '0;
      tcnt_q  <= '0;
      tport_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      m_req_q <= m_req_d;
      h_req_q <= h_req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      wait_q  <= wait_d;
      tcnt_q  <= tcnt_d;
      tport_q <= tport_d;
    end
  end

  assign wb_ack_o            = ack_q;
  assign wb_err_o            = err_q;
  assign wb_rty_o            = 1'b0;
  assign wb_dat_o            = rdat_q;
  assign m_cyc_o             = m_req_q;
  assign m_stb_o             = m_req_q;
  assign m_we_o              = we_q;
  assign m_adr_o             = adr_q[SUB_ADR_BITS-1:0];
  assign m_dat_o             = wdat_q;
  assign m_sel_o             = sel_q;
  assign h_cyc_o             = h_req_q;
  assign h_stb_o             = h_req_q;
  assign h_we_o              = we_q;
  assign h_adr_o             = adr_q;
  assign h_dat_o             = wdat_q;
  assign h_sel_o             = sel_q;
  assign timeout_count_o     = tcnt_q;
  assign last_timeout_port_o = tport_q;

endmodule

// File: tb/tb_surf_wb_fanout.sv
// Directed bench for surf_wb_fanout (6 ports, high port, 4-cycle timeout); responses are
// checked by a scoreboard monitor decoupled from the stimulus.
module tb_surf_wb_fanout;

  localparam int NP = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_cyc_i, wb_stb_i, wb_we_i;
  logic [11:0]     wb_adr_i;
  logic [31:0]     wb_dat_i;
  logic [3:0]      wb_sel_i;
  logic            wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0]     wb_dat_o;
  logic [NP-1:0]   m_cyc_o, m_stb_o;
  logic            m_we_o;
  logic [5:0]      m_adr_o;
  logic [31:0]     m_dat_o;
  logic [3:0]      m_sel_o;
  logic [NP-1:0]   m_ack_i, m_err_i;
  logic [32*NP-1:0] m_dat_i;
  logic            h_cyc_o, h_stb_o, h_we_o;
  logic [10:0]     h_adr_o;
  logic [31:0]     h_dat_o;
  logic [3:0]      h_sel_o;
  logic            h_ack_i, h_err_i;
  logic [31:0]     h_dat_i;
  logic            clear_stats_i;
  logic [15:0]     timeout_count_o;
  logic [4:0]      last_timeout_port_o;

  surf_wb_fanout #(
    .NPORTS(NP), .SUB_ADR_BITS(6), .ADR_WIDTH(12), .HI_PORT_EN(1'b1), .TIMEOUT_CYCLES(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i),
    .h_cyc_o(h_cyc_o), .h_stb_o(h_stb_o), .h_we_o(h_we_o), .h_adr_o(h_adr_o),
    .h_dat_o(h_dat_o), .h_sel_o(h_sel_o),
    .h_ack_i(h_ack_i), .h_err_i(h_err_i), .h_dat_i(h_dat_i),
    .clear_stats_i(clear_stats_i), .timeout_count_o(timeout_count_o),
    .last_timeout_port_o(last_timeout_port_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Slave models: delay 0 means silent, otherwise respond after that many strobed cycles
  int          s_dly[NP];
  logic        s_ack[NP], s_err[NP];
  logic [31:0] s_dat[NP];
  int          s_cnt[NP];
  int          h_dly, h_cnt;
  logic [31:0] h_dat_v;

  always_comb begin
    m_dat_i = '0;
    for (int p = 0; p < NP; p++) m_dat_i[32*p +: 32] = s_dat[p];
  end
  assign h_dat_i = h_dat_v;

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (m_cyc_o[p] && m_stb_o[p]) begin
        s_cnt[p]   = s_cnt[p] + 1;
        m_ack_i[p] = (s_dly[p] != 0) && (s_cnt[p] >= s_dly[p]) && s_ack[p];
        m_err_i[p] = (s_dly[p] != 0) && (s_cnt[p] >= s_dly[p]) && s_err[p];
      end else begin
        s_cnt[p]   = 0;
        m_ack_i[p] = 1'b0;
        m_err_i[p] = 1'b0;
      end
    end
    if (h_cyc_o && h_stb_o) begin
      h_cnt   = h_cnt + 1;
      h_ack_i = (h_dly != 0) && (h_cnt >= h_dly);
    end else begin
      h_cnt   = 0;
      h_ack_i = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every upstream response must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (wb_ack_o || wb_err_o) begin
      chk("ack_err_exclusive", 32'(wb_ack_o & wb_err_o), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b with no pending request", wb_ack_o, wb_err_o);
      end else begin
        e = sb.pop_front();
        chk("resp_err", 32'(wb_err_o), 32'(e.err));
        chk("resp_ack", 32'(wb_ack_o), 32'(!e.err));
        if (e.chk_dat) chk("resp_dat", wb_dat_o, e.dat);
      end
    end
  end

  task automatic do_req(input logic [11:0] adr, input logic we, input logic [31:0] wdat,
                        input logic exp_err, input logic chk_dat, input logic [31:0] exp_dat,
                        input logic [NP-1:0] exp_mstb, input logic exp_hstb, input int exp_lat);
    exp_t e;
    int   n;
    e.err = exp_err; e.chk_dat = chk_dat; e.dat = exp_dat;
    sb.push_back(e);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = 4'hA;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("m_stb", 32'(m_stb_o), 32'(exp_mstb));
    chk("m_cyc", 32'(m_cyc_o), 32'(exp_mstb));
    chk("h_stb", 32'(h_stb_o), 32'(exp_hstb));
    if (exp_hstb) begin
      chk("h_cyc", 32'(h_cyc_o), 32'd1);
      chk("h_adr", 32'(h_adr_o), 32'(adr[10:0]));
      chk("h_we",  32'(h_we_o), 32'(we));
      chk("h_dat", h_dat_o, wdat);
    end else if (exp_mstb != '0) begin
      chk("m_adr", 32'(m_adr_o), 32'(adr[5:0]));
      chk("m_we",  32'(m_we_o), 32'(we));
      chk("m_dat", m_dat_o, wdat);
      chk("m_sel", 32'(m_sel_o), 32'hA);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wb_ack_o || wb_err_o) && n < 40);
    if (!(wb_ack_o || wb_err_o)) begin
      tests++;
      fails++;
      $display("FAIL resp_wait: adr=0x%03h got no response, expected one within 40 cycles", adr);
    end else if (exp_lat >= 0) begin
      chk("resp_latency", 32'(n), 32'(exp_lat));
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; clear_stats_i = 1'b0;
    m_ack_i = '0; m_err_i = '0; h_ack_i = 1'b0; h_err_i = 1'b0;
    h_dly = 0; h_cnt = 0; h_dat_v = '0;
    for (int p = 0; p < NP; p++) begin
      s_dly[p] = 0; s_ack[p] = 1'b1; s_err[p] = 1'b0; s_dat[p] = 32'h1000_0000 + p; s_cnt[p] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_err", 32'(wb_err_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_mstb", 32'(m_stb_o | m_cyc_o), 32'd0);
    chk("rst_hstb", 32'(h_stb_o | h_cyc_o), 32'd0);
    chk("rst_tcnt", 32'(timeout_count_o), 32'd0);
    chk("rst_tport", 32'(last_timeout_port_o), 32'd0);
    chk("rty", 32'(wb_rty_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    s_dly[3] = 2; s_dat[3] = 32'h12345678;
    do_req(12'h0C4, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 6'b001000, 1'b0, 3);

    h_dly = 1; h_dat_v = 32'hCAFEF00D;
    do_req(12'h800, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b1, 2);

    do_req(12'h1C0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 6'b000000, 1'b0, 1);

    s_dly[0] = 1; s_dat[0] = 32'hA5A5_0001;
    do_req(12'h03F, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001, 6'b000001, 1'b0, 2);

    s_dly[2] = 1; s_err[2] = 1'b1; s_ack[2] = 1'b1;
    do_req(12'h080, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'hDEADBEEF, 6'b000100, 1'b0, 2);

    s_dly[5] = 3; s_err[5] = 1'b1; s_ack[5] = 1'b0;
    do_req(12'h155, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 6'b100000, 1'b0, 4);

    do_req(12'h042, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 6'b000010, 1'b0, -1);
    chk("tcnt_after_p1", 32'(timeout_count_o), 32'd1);
    chk("tport_after_p1", 32'(last_timeout_port_o), 32'd1);

    h_dly = 0;
    do_req(12'hFFF, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 32'hDEADBEEF, 6'b000000, 1'b1, -1);
    chk("tcnt_after_hi", 32'(timeout_count_o), 32'd2);
    chk("tport_after_hi", 32'(last_timeout_port_o), 32'd16);

    clear_stats_i = 1'b1;
    @(negedge clk);
    clear_stats_i = 1'b0;
    chk("tcnt_cleared", 32'(timeout_count_o), 32'd0);
    chk("tport_cleared", 32'(last_timeout_port_o), 32'd0);

    // Upstream abort: strobes fall, no response, no timeout counted
    wb_adr_i = 12'h041; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("abort_stb_up", 32'(m_stb_o), 32'b000010);
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    chk("abort_stb_down", 32'(m_stb_o | m_cyc_o), 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_timeout", 32'(timeout_count_o), 32'd0);

    // Reset mid-access: strobes drop asynchronously, no response afterwards
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_access_stb_up", 32'(m_stb_o), 32'b000010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mstb", 32'(m_stb_o | m_cyc_o), 32'd0);
    chk("async_rst_dat", wb_dat_o, 32'd0);
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_mstb", 32'(m_stb_o | m_cyc_o), 32'd0);
    chk("post_rst_resp", 32'(wb_ack_o | wb_err_o), 32'd0);

    s_dly[4] = 1; s_dat[4] = 32'h4444_0004;
    do_req(12'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_0004, 6'b010000, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
